// File: rtl/seg_display_port.sv
// Four-digit hex display port on the MCU I/O bus: two-byte tear-free value
// capture plus multiplexed common-anode 7-segment scan with blanking.
module seg_display_port #(
  parameter logic [7:0] LO_ID        = 8'h81,
  parameter logic [7:0] HI_ID        = 8'h82,
  parameter logic [7:0] CTRL_ID      = 8'h83,
  parameter int         DIGIT_CYCLES = 50000,
  parameter int         BLANK_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] SEGS,
  output logic [3:0] AN
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [7:0]       shadow_hi;
  logic [15:0]      disp;
  logic [7:0]       ctrl;
  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       digit_idx;

  logic [3:0] nibble;
  logic [3:0] lz_blank;
  logic [6:0] glyph;
  logic       dp_on;
  logic [3:0] an_next;
  logic [7:0] segs_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // The high byte waits in a shadow so the pair lands in disp in one edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_hi <= 8'h00;
      disp      <= 16'h0000;
      ctrl      <= 8'h01;
    end else if (IO_STRB) begin
      if (PORT_ID == HI_ID)
        shadow_hi <= OUT_PORT;
      else if (PORT_ID == LO_ID)
        disp <= {shadow_hi, OUT_PORT};
      else if (PORT_ID == CTRL_ID)
        ctrl <= OUT_PORT;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (!ctrl[0]) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_cnt == CNT_LAST) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // A digit is a leading zero only if it and every digit to its left are zero.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (disp[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (disp[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (disp[7:4] == 4'h0);

    case (digit_idx)
      2'd0:    nibble = disp[3:0];
      2'd1:    nibble = disp[7:4];
      2'd2:    nibble = disp[11:8];
      default: nibble = disp[15:12];
    endcase

    dp_on = ctrl[4 + digit_idx];
    glyph = (ctrl[1] && lz_blank[digit_idx]) ? 7'h7F : hex_decode(nibble);

    an_next   = 4'hF;
    segs_next = 8'hFF;
    if (ctrl[0] && (slot_cnt >= CNT_BLANK)) begin
      an_next[digit_idx] = 1'b0;
      segs_next          = {~dp_on, glyph};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AN   <= 4'hF;
      SEGS <= 8'hFF;
    end else begin
      AN   <= an_next;
      SEGS <= segs_next;
    end
  end

endmodule

// File: tb/tb_seg_display_port.sv
// Directed bench for seg_display_port with a short scan (8-cycle slots, 2 blank).
module tb_seg_display_port;

  localparam logic [7:0] LO_ID   = 8'h81;
  localparam logic [7:0] HI_ID   = 8'h82;
  localparam logic [7:0] CTRL_ID = 8'h83;

  logic       CLK;
  logic       RST_N;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] SEGS;
  logic [3:0] AN;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string      name;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] ctrl;
    int         digit;
    logic [3:0] an;
    logic [7:0] segs;
  } vec_t;

  vec_t vecs[$];

  seg_display_port #(
    .LO_ID(LO_ID), .HI_ID(HI_ID), .CTRL_ID(CTRL_ID),
    .DIGIT_CYCLES(8), .BLANK_CYCLES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .SEGS(SEGS), .AN(AN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [3:0] expAn,
                             input logic [7:0] expSegs);
    checkCount++;
    if (AN === expAn && SEGS === expSegs)
      passCount++;
    else
      $display("[TB] FAIL %s: AN=%h SEGS=%h, expected AN=%h SEGS=%h",
               name, AN, SEGS, expAn, expSegs);
  endtask

  task automatic checkCount6(input string name, input int got, input int want);
    checkCount++;
    if (got == want)
      passCount++;
    else
      $display("[TB] FAIL %s: count=%0d, expected %0d", name, got, want);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Drives one strobed bus write; returns 1ns after the edge that takes it.
  task automatic writeReg(input logic [7:0] id, input logic [7:0] data);
    @(negedge CLK);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    @(posedge CLK);
    #1;
    IO_STRB = 1'b0;
  endtask

  // Loads a value and control word, then restarts the scan at digit 0, count 0.
  task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo,
                               input logic [7:0] ctrl);
    writeReg(HI_ID, hi);
    writeReg(LO_ID, lo);
    writeReg(CTRL_ID, ctrl & 8'hFE);
    writeReg(CTRL_ID, ctrl);
  endtask

  initial begin
    int cntE, cntD, cntB, cnt7, cntDark;

    RST_N = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;

    vecs.push_back('{"12AB d0", 8'h12, 8'hAB, 8'h01, 0, 4'hE, 8'h83});
    vecs.push_back('{"12AB d1", 8'h12, 8'hAB, 8'h01, 1, 4'hD, 8'h88});
    vecs.push_back('{"12AB d2", 8'h12, 8'hAB, 8'h01, 2, 4'hB, 8'hA4});
    vecs.push_back('{"12AB d3", 8'h12, 8'hAB, 8'h01, 3, 4'h7, 8'hF9});
    vecs.push_back('{"3DE9 d0", 8'h3D, 8'hE9, 8'h01, 0, 4'hE, 8'h90});
    vecs.push_back('{"3DE9 d1", 8'h3D, 8'hE9, 8'h01, 1, 4'hD, 8'h86});
    vecs.push_back('{"3DE9 d2", 8'h3D, 8'hE9, 8'h01, 2, 4'hB, 8'hA1});
    vecs.push_back('{"3DE9 d3", 8'h3D, 8'hE9, 8'h01, 3, 4'h7, 8'hB0});
    vecs.push_back('{"lzb 0050 d3", 8'h00, 8'h50, 8'h03, 3, 4'h7, 8'hFF});
    vecs.push_back('{"lzb 0050 d2", 8'h00, 8'h50, 8'h03, 2, 4'hB, 8'hFF});
    vecs.push_back('{"lzb 0050 d1", 8'h00, 8'h50, 8'h03, 1, 4'hD, 8'h92});
    vecs.push_back('{"lzb 0050 d0", 8'h00, 8'h50, 8'h03, 0, 4'hE, 8'hC0});
    vecs.push_back('{"lzb 0000 d3", 8'h00, 8'h00, 8'h03, 3, 4'h7, 8'hFF});
    vecs.push_back('{"lzb 0000 d1", 8'h00, 8'h00, 8'h03, 1, 4'hD, 8'hFF});
    vecs.push_back('{"lzb 0000 d0", 8'h00, 8'h00, 8'h03, 0, 4'hE, 8'hC0});
    vecs.push_back('{"lzb 1005 d2", 8'h10, 8'h05, 8'h03, 2, 4'hB, 8'hC0});
    vecs.push_back('{"lzb 1005 d3", 8'h10, 8'h05, 8'h03, 3, 4'h7, 8'hF9});
    vecs.push_back('{"dp 21 d1", 8'h12, 8'hAB, 8'h21, 1, 4'hD, 8'h08});
    vecs.push_back('{"dp 21 d0", 8'h12, 8'hAB, 8'h21, 0, 4'hE, 8'h83});
    vecs.push_back('{"dp 21 d2", 8'h12, 8'hAB, 8'h21, 2, 4'hB, 8'hA4});
    vecs.push_back('{"dp on blank d3", 8'h00, 8'h05, 8'h83, 3, 4'h7, 8'h7F});
    vecs.push_back('{"dp on blank d0", 8'h00, 8'h05, 8'h83, 0, 4'hE, 8'h92});
    vecs.push_back('{"reserved 0D d0", 8'h00, 8'h0C, 8'h0D, 0, 4'hE, 8'hC6});
    vecs.push_back('{"reserved 0D d1", 8'h00, 8'h0C, 8'h0D, 1, 4'hD, 8'hC0});
    vecs.push_back('{"FF00 d3", 8'hFF, 8'h00, 8'h01, 3, 4'h7, 8'h8E});

    // Reset: dark throughout, first lit slot three edges after release.
    tick(3);
    checkOutput("in reset", 4'hF, 8'hFF);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(2);
    checkOutput("post-reset blank", 4'hF, 8'hFF);
    tick(1);
    checkOutput("post-reset first lit", 4'hE, 8'hC0);

    // Table: each digit is dark for counts 0..1 and lit for counts 2..7.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].hi, vecs[i].lo, vecs[i].ctrl);
      tick(8 * vecs[i].digit + 2);
      checkOutput({vecs[i].name, " blank"}, 4'hF, 8'hFF);
      tick(1);
      checkOutput({vecs[i].name, " first"}, vecs[i].an, vecs[i].segs);
      tick(5);
      checkOutput({vecs[i].name, " last"}, vecs[i].an, vecs[i].segs);
      tick(1);
      checkOutput({vecs[i].name, " next blank"}, 4'hF, 8'hFF);
    end

    // Full frame: each anode lit for exactly 6 of its 8 cycles.
    applyStimulus(8'h12, 8'hAB, 8'h01);
    cntE = 0; cntD = 0; cntB = 0; cnt7 = 0; cntDark = 0;
    for (int k = 0; k < 32; k++) begin
      tick(1);
      case (AN)
        4'hE: cntE++;
        4'hD: cntD++;
        4'hB: cntB++;
        4'h7: cnt7++;
        4'hF: cntDark++;
        default: ;
      endcase
    end
    checkCount6("frame digit0 lit", cntE, 6);
    checkCount6("frame digit1 lit", cntD, 6);
    checkCount6("frame digit2 lit", cntB, 6);
    checkCount6("frame digit3 lit", cnt7, 6);
    checkCount6("frame dark", cntDark, 8);

    // Shadow hold: HI alone changes nothing; LO mid-slot commits next edge.
    writeReg(HI_ID, 8'hFF);
    writeReg(CTRL_ID, 8'h00);
    writeReg(CTRL_ID, 8'h01);
    tick(27);
    checkOutput("shadow hold d3", 4'h7, 8'hF9);
    applyStimulus(8'hFF, 8'hAB, 8'h01);
    writeReg(HI_ID, 8'h12);
    tick(3);
    checkOutput("shadow pre-commit d0", 4'hE, 8'h83);
    writeReg(LO_ID, 8'h00);
    checkOutput("commit edge still old", 4'hE, 8'h83);
    tick(1);
    checkOutput("commit next edge", 4'hE, 8'hC0);
    tick(21);
    checkOutput("committed d3", 4'h7, 8'hF9);

    // Disable mid-slot, then re-enable from digit 0.
    applyStimulus(8'h12, 8'hAB, 8'h01);
    tick(4);
    checkOutput("before disable", 4'hE, 8'h83);
    writeReg(CTRL_ID, 8'h00);
    checkOutput("disable write edge", 4'hE, 8'h83);
    tick(1);
    checkOutput("disabled", 4'hF, 8'hFF);
    tick(5);
    checkOutput("still disabled", 4'hF, 8'hFF);
    writeReg(CTRL_ID, 8'h01);
    tick(2);
    checkOutput("re-enable blank", 4'hF, 8'hFF);
    tick(1);
    checkOutput("re-enable lit", 4'hE, 8'h83);

    // Ignored IDs and an unstrobed write leave every register alone.
    applyStimulus(8'h12, 8'hAB, 8'h01);
    writeReg(8'h40, 8'h77);
    writeReg(8'h84, 8'h00);
    @(negedge CLK);
    PORT_ID = LO_ID; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("ignored ids d0", 4'hE, 8'h83);
    writeReg(LO_ID, 8'hAB);
    writeReg(CTRL_ID, 8'h00);
    writeReg(CTRL_ID, 8'h01);
    tick(27);
    checkOutput("ignored ids shadow", 4'h7, 8'hF9);

    // Asynchronous reset during digit 2.
    applyStimulus(8'h12, 8'hAB, 8'h01);
    tick(20);
    checkOutput("before async reset", 4'hB, 8'hA4);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput("async reset dark", 4'hF, 8'hFF);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(3);
    checkOutput("after async reset", 4'hE, 8'hC0);
    tick(8);
    checkOutput("after async reset d1", 4'hD, 8'hC0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
